// File: rtl/dc_tone_pkg.sv
// Shared types and constants for the dc_tone_gen sine generator.
// Holds sample widths, quadrant encoding and the saturating adder.
package dc_tone_pkg;

  localparam int DATA_W = 9;
  localparam int AMP_W  = 8;

  localparam logic signed [DATA_W-1:0] SAT_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  // Two's-complement add clamped to the sample range.
  function automatic logic [DATA_W-1:0] sat_add(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? SAT_MIN : SAT_MAX;
    return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/dc_tone_quarter_lut.sv
// Quarter-wave sine ROM, 64 x 8 bit, combinational.
// Entry k holds round(255*sin(pi/2*(k+0.5)/64)).
module dc_tone_quarter_lut
  import dc_tone_pkg::*;
#(
  parameter int LUT_AW = 6
) (
  input  logic [LUT_AW-1:0] i_addr,
  output logic [AMP_W-1:0]  o_mag
);

  always_comb begin
    o_mag = '0;
    case (i_addr)
      6'd0:  o_mag = 8'd3;
      6'd1:  o_mag = 8'd9;
      6'd2:  o_mag = 8'd16;
      6'd3:  o_mag = 8'd22;
      6'd4:  o_mag = 8'd28;
      6'd5:  o_mag = 8'd34;
      6'd6:  o_mag = 8'd41;
      6'd7:  o_mag = 8'd47;
      6'd8:  o_mag = 8'd53;
      6'd9:  o_mag = 8'd59;
      6'd10: o_mag = 8'd65;
      6'd11: o_mag = 8'd71;
      6'd12: o_mag = 8'd77;
      6'd13: o_mag = 8'd83;
      6'd14: o_mag = 8'd89;
      6'd15: o_mag = 8'd95;
      6'd16: o_mag = 8'd100;
      6'd17: o_mag = 8'd106;
      6'd18: o_mag = 8'd112;
      6'd19: o_mag = 8'd117;
      6'd20: o_mag = 8'd123;
      6'd21: o_mag = 8'd128;
      6'd22: o_mag = 8'd134;
      6'd23: o_mag = 8'd139;
      6'd24: o_mag = 8'd144;
      6'd25: o_mag = 8'd149;
      6'd26: o_mag = 8'd154;
      6'd27: o_mag = 8'd159;
      6'd28: o_mag = 8'd164;
      6'd29: o_mag = 8'd169;
      6'd30: o_mag = 8'd174;
      6'd31: o_mag = 8'd178;
      6'd32: o_mag = 8'd183;
      6'd33: o_mag = 8'd187;
      6'd34: o_mag = 8'd191;
      6'd35: o_mag = 8'd195;
      6'd36: o_mag = 8'd199;
      6'd37: o_mag = 8'd203;
      6'd38: o_mag = 8'd207;
      6'd39: o_mag = 8'd210;
      6'd40: o_mag = 8'd214;
      6'd41: o_mag = 8'd217;
      6'd42: o_mag = 8'd220;
      6'd43: o_mag = 8'd223;
      6'd44: o_mag = 8'd226;
      6'd45: o_mag = 8'd229;
      6'd46: o_mag = 8'd232;
      6'd47: o_mag = 8'd234;
      6'd48: o_mag = 8'd237;
      6'd49: o_mag = 8'd239;
      6'd50: o_mag = 8'd241;
      6'd51: o_mag = 8'd243;
      6'd52: o_mag = 8'd245;
      6'd53: o_mag = 8'd247;
      6'd54: o_mag = 8'd248;
      6'd55: o_mag = 8'd249;
      6'd56: o_mag = 8'd251;
      6'd57: o_mag = 8'd252;
      6'd58: o_mag = 8'd253;
      6'd59: o_mag = 8'd253;
      6'd60: o_mag = 8'd254;
      6'd61: o_mag = 8'd255;
      6'd62: o_mag = 8'd255;
      6'd63: o_mag = 8'd255;
      default: o_mag = '0;
    endcase
  end

endmodule

// File: rtl/dc_tone_gen.sv
// Two-stage sine tone generator feeding dc_filter at the 3 MHz rate.
// Optional DC offset with saturation when DC_TONE_OFFSET_EN is defined.
module dc_tone_gen
  import dc_tone_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6
) (
  input  logic               CLK_24M,
  input  logic               reset,
  input  logic               enable_3M,
  input  logic               tone_en,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [AMP_W-1:0]   amplitude,
`ifdef DC_TONE_OFFSET_EN
  input  logic [DATA_W-1:0]  offset,
`endif
  output logic [DATA_W-1:0]  o_data,
  output logic               o_valid
);

  localparam int IDX_W = LUT_AW + 2;

  logic [PHASE_W-1:0] r_phase;
  logic               r_s1_valid;
  logic [IDX_W-1:0]   r_s1_idx;
  logic [AMP_W-1:0]   r_s1_amp;
  logic               r_s1_en;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid;

  quad_e              w_quad;
  logic [LUT_AW-1:0]  w_addr;
  logic [LUT_AW-1:0]  w_lut_addr;
  logic [AMP_W-1:0]   w_lut;
  logic [AMP_W-1:0]   w_mag;
  logic [AMP_W-1:0]   w_unused_frac;
  logic               w_neg;
  logic [DATA_W-1:0]  w_tone;
  logic [DATA_W-1:0]  w_result;

  // Phase accumulator; tone_en low parks it at 0 so a restart is coherent.
  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      r_phase <= '0;
    end else if (enable_3M) begin
      r_phase <= tone_en ? r_phase + phase_inc : '0;
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_amp   <= '0;
      r_s1_en    <= 1'b0;
    end else begin
      r_s1_valid <= enable_3M;
      if (enable_3M) begin
        r_s1_idx <= r_phase[PHASE_W-1 -: IDX_W];
        r_s1_amp <= amplitude;
        r_s1_en  <= tone_en;
      end
    end
  end

  assign w_quad = quad_e'(r_s1_idx[IDX_W-1 -: 2]);
  assign w_addr = r_s1_idx[LUT_AW-1:0];

  // Odd quadrants walk the quarter table backwards.
  always_comb begin
    w_lut_addr = w_addr;
    w_neg      = 1'b0;
    unique case (w_quad)
      Q0: begin
        w_lut_addr = w_addr;
        w_neg      = 1'b0;
      end
      Q1: begin
        w_lut_addr = ~w_addr;
        w_neg      = 1'b0;
      end
      Q2: begin
        w_lut_addr = w_addr;
        w_neg      = 1'b1;
      end
      Q3: begin
        w_lut_addr = ~w_addr;
        w_neg      = 1'b1;
      end
      default: begin
        w_lut_addr = w_addr;
        w_neg      = 1'b0;
      end
    endcase
  end

  dc_tone_quarter_lut #(
    .LUT_AW (LUT_AW)
  ) u_lut (
    .i_addr (w_lut_addr),
    .o_mag  (w_lut)
  );

  assign {w_mag, w_unused_frac} = w_lut * r_s1_amp;

  always_comb begin
    w_tone = '0;
    if (r_s1_en)
      w_tone = w_neg ? -{1'b0, w_mag} : {1'b0, w_mag};
  end

`ifdef DC_TONE_OFFSET_EN
  logic [DATA_W-1:0] r_s1_off;

  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      r_s1_off <= '0;
    end else if (enable_3M) begin
      r_s1_off <= offset;
    end
  end

  assign w_result = sat_add(w_tone, r_s1_off);
`else
  assign w_result = w_tone;
`endif

  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_s1_valid;
      if (r_s1_valid)
        r_data <= w_result;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_dc_tone_gen.sv
// Scoreboard bench for dc_tone_gen against a real-valued sine model.
// Directed tone cases, mid-stream reset, random traffic and a long wrap run.
module tb_dc_tone_gen;

  logic        CLK_24M = 1'b0;
  logic        reset;
  logic        enable_3M;
  logic        tone_en;
  logic [15:0] phase_inc;
  logic [7:0]  amplitude;
`ifdef DC_TONE_OFFSET_EN
  logic [8:0]  offset;
`endif
  logic [8:0]  o_data;
  logic        o_valid;

  always #21 CLK_24M = ~CLK_24M;

  dc_tone_gen dut (
    .CLK_24M   (CLK_24M),
    .reset     (reset),
    .enable_3M (enable_3M),
    .tone_en   (tone_en),
    .phase_inc (phase_inc),
    .amplitude (amplitude),
`ifdef DC_TONE_OFFSET_EN
    .offset    (offset),
`endif
    .o_data    (o_data),
    .o_valid   (o_valid)
  );

  typedef struct {
    int issue;
    int val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lut[64];
  int   m_phase;
  int   m_off;
  int   hold_val;
  int   got;
  exp_t mon_e;

  always @(posedge CLK_24M) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic int ref_sample(int ph, int amp, bit en, int off);
    int p8, qd, a, m, s;
    s = 0;
    if (en) begin
      p8 = ph / 256;
      qd = p8 / 64;
      a  = p8 % 64;
      m  = (lut[(qd % 2 == 1) ? 63 - a : a] * amp) / 256;
      s  = (qd >= 2) ? -m : m;
    end
    s = s + off;
    if (s > 255)  s = 255;
    if (s < -256) s = -256;
    return s;
  endfunction

  always @(negedge CLK_24M) begin
    got = $signed(o_data);
    if (o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("sample", got, mon_e.val);
        chk("latency", cyc, mon_e.issue + 2);
      end
      hold_val = got;
    end else if (!reset) begin
      chk("hold", got, hold_val);
    end
  end

  task automatic idle(input int n);
    enable_3M = 1'b0;
    repeat (n) begin
      @(posedge CLK_24M);
      #1;
    end
  endtask

  task automatic strobe(input bit en, input int inc, input int amp,
                        input bit use_fixed, input int fixed);
    int e;
    tone_en   = en;
    phase_inc = inc[15:0];
    amplitude = amp[7:0];
`ifdef DC_TONE_OFFSET_EN
    offset    = m_off[8:0];
`endif
    enable_3M = 1'b1;
    e = use_fixed ? fixed : ref_sample(m_phase, amp, en, m_off);
    q.push_back('{cyc, e});
    m_phase = en ? (m_phase + inc) % 65536 : 0;
    @(posedge CLK_24M);
    #1;
    enable_3M = 1'b0;
  endtask

  task automatic reset_mid_stream();
    int k;
    for (int i = 0; i < 5; i++) strobe(1, 'h4000, 255, 0, 0);
    k = cyc;
    reset     = 1'b1;
    enable_3M = 1'b1;
    tone_en   = 1'b1;
    while (q.size() > 0 && q[$].issue >= k - 1) void'(q.pop_back());
    m_phase = 0;
    @(posedge CLK_24M);
    #1;
    enable_3M = 1'b0;
    idle(2);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_data", $signed(o_data), 0);
    hold_val = 0;
    reset = 1'b0;
    idle(5);
    chk("rst_queue", q.size(), 0);
    strobe(1, 'h4000, 255, 1, 2);
    idle(3);
  endtask

  initial begin
    #(64'd9000000);
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    reset     = 1'b1;
    enable_3M = 1'b0;
    tone_en   = 1'b0;
    phase_inc = '0;
    amplitude = '0;
    m_phase   = 0;
    m_off     = 0;
    hold_val  = 0;
`ifdef DC_TONE_OFFSET_EN
    offset    = '0;
`endif
    for (int k = 0; k < 64; k++)
      lut[k] = $rtoi(255.0 * $sin(3.14159265358979 * (k + 0.5) / 128.0)
                     + 0.5);

    repeat (3) @(posedge CLK_24M);
    #1;
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_data", $signed(o_data), 0);
    reset = 1'b0;
    idle(2);

    strobe(1, 'h4000, 255, 1, 2);    idle(7);
    strobe(1, 'h4000, 255, 1, 254);  idle(7);
    strobe(1, 'h4000, 255, 1, -2);   idle(7);
    strobe(1, 'h4000, 255, 1, -254); idle(7);

    strobe(1, 'h4000, 128, 1, 1);    idle(7);
    strobe(1, 'h4000, 128, 1, 127);  idle(7);
    strobe(1, 'h4000, 128, 1, -1);   idle(7);
    strobe(1, 'h4000, 128, 1, -127); idle(7);

    strobe(1, 'h4000, 255, 1, 2);
    strobe(1, 'h4000, 255, 1, 254);
    strobe(1, 'h4000, 255, 1, -2);
    strobe(1, 'h4000, 255, 1, -254);
    idle(4);

    strobe(1, 'h4000, 255, 1, 2);   idle(3);
    strobe(1, 'h4000, 255, 1, 254); idle(3);
    strobe(0, 'h4000, 255, 1, 0);   idle(3);
    strobe(1, 'h4000, 255, 1, 2);   idle(3);

    strobe(0, 0, 255, 1, 0);
    strobe(1, 0, 255, 1, 2);
    strobe(1, 0, 255, 1, 2);
    strobe(1, 0, 255, 1, 2);
    idle(4);

    reset_mid_stream();

`ifdef DC_TONE_OFFSET_EN
    m_off = 100;
    strobe(0, 'h4000, 255, 1, 100);
    strobe(1, 'h4000, 255, 1, 102);
    strobe(1, 'h4000, 255, 1, 255);
    strobe(1, 'h4000, 255, 1, 98);
    strobe(1, 'h4000, 255, 1, -154);
    m_off = -100;
    strobe(0, 'h4000, 255, 1, -100);
    strobe(0, 'h1234, 77, 1, -100);
    strobe(0, 'h0001, 200, 1, -100);
    idle(4);
`endif

    for (int i = 0; i < 1500; i++) begin
`ifdef DC_TONE_OFFSET_EN
      m_off = int'($urandom_range(511)) - 256;
`endif
      strobe($urandom_range(9) != 0, int'($urandom_range(65535)),
             int'($urandom_range(255)), 0, 0);
      gap = int'($urandom_range(3));
      if (gap > 0) idle(gap);
    end
    idle(4);

    m_off = 0;
    strobe(0, 0, 255, 1, 0);
    for (int i = 0; i < 70000; i++)
      strobe(1, 'hFFFF, 255, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    chk("drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dc_tone_gen.md
DC_TONE_GEN -- requirements
Module: dc_tone_gen

Interface
REQ-001 Parameter: PHASE_W, 16, phase accumulator width in bits; the top 8 bits address the sine table.
REQ-002 Parameter: LUT_AW, 6, quarter-wave table address width (64 entries).
REQ-003 Port: CLK_24M  input  1  system clock, 24 MHz.
REQ-004 Port: reset  input  1  reset, synchronous and active-high.
REQ-005 Port: enable_3M  input  1  sample strobe, one CLK_24M cycle wide.
REQ-006 Port: tone_en  input  1  tone enable; when low, samples are zero and phase is held at 0.
REQ-007 Port: phase_inc  input  PHASE_W  phase step per sample, unsigned.
REQ-008 Port: amplitude  input  8  unsigned gain, 0..255, scaled by 1/256.
REQ-009 Port: offset  input  9  signed DC offset; present only with DC_TONE_OFFSET_EN.
REQ-010 Port: o_data  output  9  signed two's-complement sample; drives c_data of dc_filter.
REQ-011 Port: o_valid  output  1  one-cycle pulse marking a new o_data.

Function
REQ-012 The block SHALL hold a PHASE_W-bit phase accumulator that wraps modulo 2^PHASE_W.
REQ-013 On each enable_3M cycle, the block SHALL capture phase, amplitude and tone_en into stage 1.
- Same cycle: phase advances by phase_inc if tone_en=1.
- Same cycle: phase is forced to 0 if tone_en=0.
REQ-014 Stage 1 SHALL select the table entry from the quadrant q = phase[PHASE_W-1:PHASE_W-2] and address a = the next LUT_AW bits.
- q0: +lut[a].
- q1: +lut[63-a].
- q2: -lut[a].
- q3: -lut[63-a].
REQ-015 Table contents SHALL be lut[k] = round(255*sin(pi/2*(k+0.5)/64)), 8-bit unsigned; lut[0]=3, lut[63]=255.
REQ-016 Stage 2 SHALL compute mag = (lut_value*amplitude)>>8, range 0..254, and then apply the quadrant sign.
REQ-017 A captured tone_en=0 SHALL give a stage-2 result of 0.
REQ-018 Latency: an enable_3M in cycle n SHALL update o_data and pulse o_valid in cycle n+2.
REQ-019 o_data SHALL hold its value between o_valid pulses.
REQ-020 The pipeline SHALL be fully pipelined: back-to-back enable_3M strobes each yield one sample, in order, with none lost.
REQ-021 phase_inc, amplitude and offset changes SHALL take effect on the next strobe; an in-flight sample SHALL use its captured values.
REQ-022 A tone_en fall SHALL let an in-flight sample complete; the following samples SHALL be 0 and phase SHALL restart from 0.
REQ-023 phase_inc=0 with tone_en=1 SHALL produce a constant sample equal to the phase-0 value, +2 at amplitude 255.

Reset
REQ-024 While reset=1, the block SHALL hold phase=0, both pipeline stages invalid, o_data=0 and o_valid=0.
REQ-025 reset SHALL take priority over a coincident enable_3M; that strobe and all in-flight samples SHALL be discarded.
REQ-026 The first strobe after reset is released SHALL use phase 0.

Configuration
REQ-027 With DC_TONE_OFFSET_EN defined, the offset port SHALL exist.
- Stage 2 adds offset to the signed result, saturating to [-256, 255].
- Offset applies even when tone_en=0, so output = offset.
REQ-028 Without DC_TONE_OFFSET_EN, there SHALL be no offset port and no adder, and the result is passed straight through.

Structure
REQ-029 Package dc_tone_pkg SHALL hold DATA_W=9, AMP_W=8, the quadrant enum (Q0..Q3) and the saturation limits SAT_MAX=255 and SAT_MIN=-256.
REQ-030 Sub-module dc_tone_quarter_lut SHALL be a combinational 64x8 ROM, addr in and magnitude out, instantiated once.

Verification
REQ-031 phase_inc=0x4000, amplitude=255, tone_en=1, strobe every 8 cycles -> o_data cycles 2, 254, -2, -254; each sample 2 cycles after its strobe.
REQ-032 phase_inc=0x4000, amplitude=128 -> o_data cycles 1, 127, -1, -127.
REQ-033 Back-to-back strobes for 4 cycles with phase_inc=0x4000 -> four consecutive o_valid pulses carrying 2, 254, -2, -254.
REQ-034 Assert reset during a strobe mid-stream, then release -> no o_valid during or after reset until the next strobe; the first sample is 2.
REQ-035 With DC_TONE_OFFSET_EN, offset=+100, amplitude=255, phase_inc=0x4000 -> o_data 102, 255 (saturated), 98, -154.
REQ-036 With DC_TONE_OFFSET_EN, offset=-100, tone_en=0 -> o_data constant -100.
REQ-037 Toggle tone_en low for one strobe and high again -> that strobe's sample is 0; the next sample is 2 (phase restarted).
REQ-038 phase_inc=0xFFFF for 70000 strobes -> the accumulator wraps with no glitch, and the output matches a reference model bit-exactly.
